uart_core: RTL

Full-duplex parametrised UART with independent RX and TX engines, valid/ready byte interfaces, a runtime baud divisor, and error reporting. It supersedes the fixed 8N1 loopback UART. It sits between the board serial pins and any byte-stream consumer, such as a command parser or loopback glue. The RX input is synchronised internally; the TX output is registered.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_timer.sv | 66 ++++++
 rtl/uart_core.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the uart_core slice: the engine state encoding used
// by both the RX and TX engines, the smallest usable baud divisor, and the
// idle level of the serial line.
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int   MIN_DIVISOR = 4;
    localparam logic LINE_IDLE   = 1'b1;

endpackage

// File: rtl/uart_baud_timer.sv
// ---------------------------------------------------------------------------
// uart_baud_timer
// Bit-period timer used once per UART engine. On i_load it latches the
// effective divisor (i_divisor clamped to at least MIN_DIVISOR) and starts a
// countdown of either a full or a half period. While i_run is high it emits a
// one-cycle o_tick every time the countdown expires and then reloads a full
// period, so the first tick can land at mid-bit (RX) or at bit end (TX).
//
// Ports:
//   clk        system clock
//   i_reset    synchronous, active-high reset
//   i_load     start a new frame: latch divisor and load the counter
//   i_half     with i_load, make the first interval D/2 (floor) cycles
//   i_run      timer is counting (engine not idle)
//   i_divisor  requested clocks per bit
//   o_tick     one-cycle pulse when the current interval expires
// ---------------------------------------------------------------------------
module uart_baud_timer
    import uart_pkg::*;
#(
    parameter int DIV_BITS = 16
) (
    input  logic                clk,
    input  logic                i_reset,
    input  logic                i_load,
    input  logic                i_half,
    input  logic                i_run,
    input  logic [DIV_BITS-1:0] i_divisor,
    output logic                o_tick
);

    logic [DIV_BITS-1:0] effective_div;
    logic [DIV_BITS-1:0] period_q;
    logic [DIV_BITS-1:0] count_q;

    // Divisors below the minimum would leave no room for mid-bit sampling,
    // so they are raised to the minimum before being latched.
    always_comb begin
        effective_div = i_divisor;
        if (i_divisor < DIV_BITS'(MIN_DIVISOR)) begin
            effective_div = DIV_BITS'(MIN_DIVISOR);
        end
    end

    // The period is captured only at frame start so a divisor change in the
    // middle of a frame cannot stretch or shrink the bits already in flight.
    // The counter counts down to zero and reloads a full period each time.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            period_q <= '0;
            count_q  <= '0;
        end else if (i_load) begin
            period_q <= effective_div;
            count_q  <= (i_half ? (effective_div >> 1) : effective_div) - DIV_BITS'(1);
        end else if (i_run) begin
            if (count_q == '0) begin
                count_q <= period_q - DIV_BITS'(1);
            end else begin
                count_q <= count_q - DIV_BITS'(1);
            end
        end
    end

    assign o_tick = i_run && !i_load && (count_q == '0);

endmodule

// File: rtl/uart_core.sv
// ---------------------------------------------------------------------------
// uart_core
// Full-duplex UART with independent TX and RX engines, valid/ready byte
// interfaces, a runtime baud divisor and per-frame error pulses. The RX line
// is synchronised internally and the TX line is driven from a flop.
//
// Build option: define UART_PARITY_EN to insert a parity bit after the data
// (even, or odd when PARITY_ODD=1). Without it there is no parity slot and
// o_rx_parity_err is held at 0.
//
// Ports:
//   clk, i_reset       clock and synchronous active-high reset
//   i_divisor          clocks per bit, values below 4 act as 4
//   i_tx_data/valid    byte to send and its request, taken when o_tx_ready
//   o_tx_ready         TX engine idle
//   o_tx_busy          TX frame in progress
//   o_rx_data/valid    received byte and its hold flag
//   i_rx_ready         consumer takes the held byte
//   o_rx_frame_err     pulse: stop bit sampled low
//   o_rx_parity_err    pulse: parity bit mismatch
//   o_rx_overrun       pulse: frame finished while a byte was still held
//   uart_txd_in        serial input from host
//   uart_rxd_out       serial output to host
// ---------------------------------------------------------------------------
module uart_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int DIV_BITS    = 16,
    parameter int SYNC_STAGES = 2,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic [DIV_BITS-1:0]  i_divisor,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic                 o_tx_busy,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    output logic                 o_rx_frame_err,
    output logic                 o_rx_parity_err,
    output logic                 o_rx_overrun,
    input  logic                 uart_txd_in,
    output logic                 uart_rxd_out
);

    localparam int BIT_W = $clog2(DATA_BITS);

`ifdef UART_PARITY_EN
    localparam uart_state_t AFTER_DATA = PARITY;
`else
    localparam uart_state_t AFTER_DATA = STOP;
`endif

    // ------------------------------------------------------------------
    // TX engine
    // ------------------------------------------------------------------
    uart_state_t          tx_state;
    uart_state_t          tx_state_next;
    logic                 tx_tick;
    logic                 tx_accept;
    logic                 tx_last_bit;
    logic                 tx_last_stop;
    logic [DATA_BITS-1:0] tx_shift;
    logic [BIT_W-1:0]     tx_bit_cnt;
    logic                 tx_stop_cnt;
    logic                 tx_line_q;
`ifdef UART_PARITY_EN
    logic                 tx_parity_q;
`endif

    assign tx_accept    = i_tx_valid && (tx_state == IDLE);
    assign tx_last_bit  = (tx_bit_cnt == BIT_W'(DATA_BITS - 1));
    assign tx_last_stop = (tx_stop_cnt == 1'(STOP_BITS - 1));

    uart_baud_timer #(.DIV_BITS(DIV_BITS)) u_tx_timer (
        .clk       (clk),
        .i_reset   (i_reset),
        .i_load    (tx_accept),
        .i_half    (1'b0),
        .i_run     (tx_state != IDLE),
        .i_divisor (i_divisor),
        .o_tick    (tx_tick)
    );

    // TX state register.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            tx_state <= IDLE;
        end else begin
            tx_state <= tx_state_next;
        end
    end

    // TX next-state: every bit slot ends on a timer tick; the stop phase
    // repeats once per configured stop bit before returning to IDLE.
    always_comb begin
        tx_state_next = tx_state;
        case (tx_state)
            IDLE:    if (tx_accept) tx_state_next = START;
            START:   if (tx_tick) tx_state_next = DATA;
            DATA:    if (tx_tick && tx_last_bit) tx_state_next = AFTER_DATA;
            PARITY:  if (tx_tick) tx_state_next = STOP;
            STOP:    if (tx_tick && tx_last_stop) tx_state_next = IDLE;
            default: tx_state_next = IDLE;
        endcase
    end

    // TX handshake outputs follow the state directly, so ready is back in
    // the cycle after the final stop cycle.
    always_comb begin
        o_tx_ready = (tx_state == IDLE);
        o_tx_busy  = (tx_state != IDLE);
    end

    // TX datapath: the line flop is updated on the same edge that changes
    // the bit slot, so each level lasts exactly one period. The shift
    // register presents the next data bit in position 0.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            tx_shift    <= '0;
            tx_bit_cnt  <= '0;
            tx_stop_cnt <= 1'b0;
            tx_line_q   <= LINE_IDLE;
`ifdef UART_PARITY_EN
            tx_parity_q <= 1'b0;
`endif
        end else begin
            case (tx_state)
                IDLE: begin
                    if (tx_accept) begin
                        tx_shift    <= i_tx_data;
                        tx_bit_cnt  <= '0;
                        tx_stop_cnt <= 1'b0;
                        tx_line_q   <= 1'b0;
`ifdef UART_PARITY_EN
                        tx_parity_q <= (^i_tx_data) ^ 1'(PARITY_ODD);
`endif
                    end
                end
                START: begin
                    if (tx_tick) begin
                        tx_line_q <= tx_shift[0];
                        tx_shift  <= tx_shift >> 1;
                    end
                end
                DATA: begin
                    if (tx_tick) begin
                        if (tx_last_bit) begin
`ifdef UART_PARITY_EN
                            tx_line_q <= tx_parity_q;
`else
                            tx_line_q <= LINE_IDLE;
`endif
                        end else begin
                            tx_line_q  <= tx_shift[0];
                            tx_shift   <= tx_shift >> 1;
                            tx_bit_cnt <= tx_bit_cnt + BIT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (tx_tick) begin
                        tx_line_q <= LINE_IDLE;
                    end
                end
                STOP: begin
                    if (tx_tick && !tx_last_stop) begin
                        tx_stop_cnt <= 1'b1;
                    end
                end
                default: tx_line_q <= LINE_IDLE;
            endcase
        end
    end

    assign uart_rxd_out = tx_line_q;

    // ------------------------------------------------------------------
    // RX engine
    // ------------------------------------------------------------------
    uart_state_t          rx_state;
    uart_state_t          rx_state_next;
    logic [SYNC_STAGES-1:0] rx_sync;
    logic                 rx_line;
    logic                 rx_prev;
    logic                 rx_fall;
    logic                 rx_start_load;
    logic                 rx_tick;
    logic                 rx_last_bit;
    logic                 rx_complete;
    logic [DATA_BITS-1:0] rx_shift;
    logic [BIT_W-1:0]     rx_bit_cnt;
`ifdef UART_PARITY_EN
    logic                 rx_parity_bad;
    logic                 rx_parity_err_q;
`endif

    assign rx_line       = rx_sync[SYNC_STAGES-1];
    assign rx_fall       = rx_prev && !rx_line;
    assign rx_start_load = (rx_state == IDLE) && rx_fall;
    assign rx_last_bit   = (rx_bit_cnt == BIT_W'(DATA_BITS - 1));

    // Metastability chain plus one extra flop for edge detection. Both
    // reset to the idle level so reset never looks like a start bit, and a
    // line held low after a bad stop bit cannot re-arm until it goes high.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            rx_sync <= '1;
            rx_prev <= LINE_IDLE;
        end else begin
            rx_sync <= {rx_sync[SYNC_STAGES-2:0], uart_txd_in};
            rx_prev <= rx_line;
        end
    end

    uart_baud_timer #(.DIV_BITS(DIV_BITS)) u_rx_timer (
        .clk       (clk),
        .i_reset   (i_reset),
        .i_load    (rx_start_load),
        .i_half    (1'b1),
        .i_run     (rx_state != IDLE),
        .i_divisor (i_divisor),
        .o_tick    (rx_tick)
    );

    // RX state register.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            rx_state <= IDLE;
        end else begin
            rx_state <= rx_state_next;
        end
    end

    // RX next-state: the first tick re-checks the start bit at half a bit;
    // a high reading there means a glitch and the engine quietly gives up.
    always_comb begin
        rx_state_next = rx_state;
        case (rx_state)
            IDLE:    if (rx_fall) rx_state_next = START;
            START:   if (rx_tick) rx_state_next = rx_line ? IDLE : DATA;
            DATA:    if (rx_tick && rx_last_bit) rx_state_next = AFTER_DATA;
            PARITY:  if (rx_tick) rx_state_next = STOP;
            STOP:    if (rx_tick) rx_state_next = IDLE;
            default: rx_state_next = IDLE;
        endcase
    end

    // RX output decode: a frame completes on the stop-bit sample.
    always_comb begin
        rx_complete = (rx_state == STOP) && rx_tick;
    end

    // RX datapath: bits arrive LSB first, so each sample enters at the top
    // of the shift register and the first bit ends up in position 0.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            rx_shift   <= '0;
            rx_bit_cnt <= '0;
`ifdef UART_PARITY_EN
            rx_parity_bad <= 1'b0;
`endif
        end else begin
            if (rx_start_load) begin
                rx_bit_cnt <= '0;
`ifdef UART_PARITY_EN
                rx_parity_bad <= 1'b0;
`endif
            end else if (rx_tick && (rx_state == DATA)) begin
                rx_shift   <= {rx_line, rx_shift[DATA_BITS-1:1]};
                rx_bit_cnt <= rx_bit_cnt + BIT_W'(1);
            end
`ifdef UART_PARITY_EN
            if (rx_tick && (rx_state == PARITY)) begin
                rx_parity_bad <= rx_line ^ (^rx_shift) ^ 1'(PARITY_ODD);
            end
`endif
        end
    end

    // Delivery and error pulses. A completing frame is loaded whenever the
    // holding register is empty or being consumed in the same cycle;
    // otherwise it is dropped and flagged as an overrun. Error pulses are
    // cleared every cycle so they last exactly one cycle.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            o_rx_data      <= '0;
            o_rx_valid     <= 1'b0;
            o_rx_frame_err <= 1'b0;
            o_rx_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
            rx_parity_err_q <= 1'b0;
`endif
        end else begin
            o_rx_frame_err <= 1'b0;
            o_rx_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
            rx_parity_err_q <= 1'b0;
`endif
            if (rx_complete) begin
                o_rx_frame_err <= !rx_line;
`ifdef UART_PARITY_EN
                rx_parity_err_q <= rx_parity_bad;
`endif
                if (!o_rx_valid || i_rx_ready) begin
                    o_rx_data  <= rx_shift;
                    o_rx_valid <= 1'b1;
                end else begin
                    o_rx_overrun <= 1'b1;
                end
            end else if (o_rx_valid && i_rx_ready) begin
                o_rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_PARITY_EN
    assign o_rx_parity_err = rx_parity_err_q;
`else
    assign o_rx_parity_err = 1'b0;
`endif

endmodule
